imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single-port synchronous instruction memory between the fetch stage (read-only requester) and the program loader/debug port (read/write requester).
- Sits between the fetch stage and the instruction memory.
- Sequences a BOOT phase, where the loader has exclusive access, and a RUN phase, where fetch has priority and a starvation counter bounds how long the loader can be held off.
- The fetch stage holds its PC whenever its grant is low.

Parameters:
- ADDR_WIDTH, 10, word-address width of the memory.
- DATA_WIDTH, 32, memory word width.
- DATA_BYTES, 4, byte lanes (DATA_WIDTH/8).
- STARVE_LIMIT, 4, consecutive denied RUN cycles after which the loader wins the port (>=1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- boot_done_i  in  1  single-cycle pulse; ends the BOOT phase.
- if_req_i  in  1  fetch read request.
- if_addr_i  in  32  fetch byte address.
- if_gnt_o  out  1  fetch request accepted this cycle (combinational).
- if_rvalid_o  out  1  fetch read data valid (one cycle after grant).
- if_rdata_o  out  DATA_WIDTH  fetch read data.
- ld_req_i  in  1  loader request.
- ld_we_i  in  1  1 = write, 0 = read.
- ld_addr_i  in  32  loader byte address.
- ld_wdata_i  in  DATA_WIDTH  write data.
- ld_be_i  in  DATA_BYTES  byte enables for writes.
- ld_gnt_o  out  1  loader request accepted this cycle (combinational).
- ld_rvalid_o  out  1  loader read data valid (one cycle after a read grant).
- ld_rdata_o  out  DATA_WIDTH  loader read data.
- mem_addr_o  out  ADDR_WIDTH  memory word address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_wen_o  out  DATA_BYTES  memory byte write enables.
- mem_rdata_i  in  DATA_WIDTH  memory read data (registered inside the memory, 1-cycle latency).
- run_o  out  1  1 when in the RUN state.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - state=BOOT, wait_cnt=0;
  - if_rvalid_o=0, ld_rvalid_o=0, run_o=0;
  - mem_addr_o register=0.
  - Reset mid-transaction drops any pending rvalid; no response is produced for it.
- State machine:
  - BOOT -> RUN on boot_done_i=1; run_o=1 from the next cycle.
  - RUN has no exit except rst; boot_done_i is ignored in RUN.
- BOOT grant rules:
  - if_gnt_o=0.
  - ld_gnt_o=ld_req_i.
- RUN grant rules:
  - starve = (wait_cnt==STARVE_LIMIT).
  - ld_gnt_o = ld_req_i & (~if_req_i | starve).
  - if_gnt_o = if_req_i & ~ld_gnt_o.
  - if_gnt_o and ld_gnt_o are never both 1.
- Starvation counter wait_cnt (width clog2(STARVE_LIMIT+1)):
  - In RUN, increments when ld_req_i=1 and ld_gnt_o=0, saturating at STARVE_LIMIT.
  - Clears to 0 on ld_gnt_o=1 or ld_req_i=0.
  - Held at 0 in BOOT.
- Memory drive, address is byte address bits [ADDR_WIDTH+1:2]:
  - Low two bits are ignored (no misalignment error).
  - Upper bits are ignored, so addresses wrap modulo DEPTH.
  - Winner's address is driven combinationally.
  - When there is no grant, mem_addr_o holds the last granted address and mem_wen_o=0.
  - mem_wen_o = ld_be_i only when ld_gnt_o & ld_we_i; otherwise 0.
  - mem_wdata_o = ld_wdata_i always.
- Responses:
  - if_rvalid_o = registered if_gnt_o.
  - ld_rvalid_o = registered (ld_gnt_o & ~ld_we_i).
  - Writes produce no rvalid; the grant is the acknowledgement.
  - if_rdata_o = ld_rdata_o = mem_rdata_i (combinational pass-through, qualified by the respective rvalid).
  - Back-to-back grants give back-to-back rvalids: throughput 1 access/cycle.
- Requesters must hold req/addr/data stable until granted. Dropping a request before its grant is legal; no state is left behind.
- BOOT with ld_req_i and boot_done_i both 1 in the same cycle: loader is granted, the transition occurs at the same edge, and the rvalid for a loader read still follows in the next cycle.

Test Plan:
- Reset, then BOOT with loader writes: ld_we_i=1 to 0x100 with data 0xDEADBEEF and be=4'hF, and to 0x104 with data 0x00000013 -> ld_gnt_o=1, mem_addr_o=0x40/0x41, mem_wen_o=4'hF, if_gnt_o=0 despite if_req_i=1, no rvalid.
- boot_done_i pulse, then fetch 0x100, 0x104 on consecutive cycles -> if_gnt_o=1 both cycles, if_rvalid_o=1 on the two following cycles, if_rdata_o=0xDEADBEEF then 0x00000013, run_o=1.
- RUN with if_req_i held 1 and ld_req_i read of 0x104 raised -> loader denied for 4 cycles (wait_cnt 1..4); 5th cycle ld_gnt_o=1, if_gnt_o=0; next cycle ld_rvalid_o=1 with 0x00000013 and wait_cnt=0.
- Partial write in RUN: ld_be_i=4'b0011, data 0x0000AAAA to 0x100 while if_req_i=0 -> immediate grant, mem_wen_o=4'b0011; subsequent fetch of 0x100 returns 0xDEADAAAA.
- Address wrap: fetch of 0x1100 (word 0x440) with ADDR_WIDTH=10 -> mem_addr_o=0x040.
- Assert rst while a fetch read is outstanding -> if_rvalid_o=0 next cycle, run_o=0, if_gnt_o=0 until the next boot_done_i.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between the fetch stage and the loader/debug port.
// BOOT gives the loader exclusive use; RUN favours fetch but bounds loader starvation.
module imem_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int DATA_BYTES   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_done_i,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  ld_req_i,
  input  logic                  ld_we_i,
  input  logic [31:0]           ld_addr_i,
  input  logic [DATA_WIDTH-1:0] ld_wdata_i,
  input  logic [DATA_BYTES-1:0] ld_be_i,
  output logic                  ld_gnt_o,
  output logic                  ld_rvalid_o,
  output logic [DATA_WIDTH-1:0] ld_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [DATA_BYTES-1:0] mem_wen_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  run_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [CNT_W-1:0]      r_waitCnt;
  logic [ADDR_WIDTH-1:0] r_lastAddr;
  logic                  r_ifRvalid;
  logic                  r_ldRvalid;
  logic                  w_ifGnt;
  logic                  w_ldGnt;
  logic                  w_starve;
  logic [ADDR_WIDTH-1:0] w_ifWord;
  logic [ADDR_WIDTH-1:0] w_ldWord;
  logic                  w_unused;

  // Byte addresses are reduced to word indices; the low and high bits simply alias.
  assign w_ifWord = if_addr_i[ADDR_WIDTH+1:2];
  assign w_ldWord = ld_addr_i[ADDR_WIDTH+1:2];
  assign w_unused = ^{if_addr_i[31:ADDR_WIDTH+2], if_addr_i[1:0],
                      ld_addr_i[31:ADDR_WIDTH+2], ld_addr_i[1:0]};

  assign w_starve = (r_waitCnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_ldGnt     = 1'b0;
    w_ifGnt     = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_ldGnt = ld_req_i;
        if (boot_done_i) begin
          w_stateNext = ST_RUN;
        end
      end
      ST_RUN: begin
        w_ldGnt = ld_req_i & (~if_req_i | w_starve);
        w_ifGnt = if_req_i & ~w_ldGnt;
      end
      default: begin
        w_stateNext = ST_BOOT;
      end
    endcase
  end

  // Counts consecutive RUN cycles in which the loader asked and lost.
  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_BOOT)) begin
      r_waitCnt <= '0;
    end else if (!ld_req_i || w_ldGnt) begin
      r_waitCnt <= '0;
    end else if (!w_starve) begin
      r_waitCnt <= r_waitCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastAddr <= '0;
    end else if (w_ldGnt) begin
      r_lastAddr <= w_ldWord;
    end else if (w_ifGnt) begin
      r_lastAddr <= w_ifWord;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifRvalid <= 1'b0;
      r_ldRvalid <= 1'b0;
    end else begin
      r_ifRvalid <= w_ifGnt;
      r_ldRvalid <= w_ldGnt & ~ld_we_i;
    end
  end

  // With no winner the address parks on the last granted word.
  always_comb begin
    mem_addr_o = r_lastAddr;
    if (w_ldGnt) begin
      mem_addr_o = w_ldWord;
    end else if (w_ifGnt) begin
      mem_addr_o = w_ifWord;
    end
  end

  assign mem_wen_o   = (w_ldGnt & ld_we_i) ? ld_be_i : '0;
  assign mem_wdata_o = ld_wdata_i;

  assign if_gnt_o    = w_ifGnt;
  assign ld_gnt_o    = w_ldGnt;
  assign if_rvalid_o = r_ifRvalid;
  assign ld_rvalid_o = r_ldRvalid;
  assign if_rdata_o  = mem_rdata_i;
  assign ld_rdata_o  = mem_rdata_i;
  assign run_o       = (r_state == ST_RUN);

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomised scoreboard bench for imem_port_arbiter with an attached behavioural memory.
// A negedge reference model predicts grants/memory drive and queues read data; a monitor checks rvalids.
module tb_imem_port_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DB    = 4;
  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          boot_done_i;
  logic          if_req_i;
  logic [31:0]   if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          ld_req_i;
  logic          ld_we_i;
  logic [31:0]   ld_addr_i;
  logic [DW-1:0] ld_wdata_i;
  logic [DB-1:0] ld_be_i;
  logic          ld_gnt_o;
  logic          ld_rvalid_o;
  logic [DW-1:0] ld_rdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DB-1:0] mem_wen_o;
  logic [DW-1:0] mem_rdata_i;
  logic          run_o;

  int checks   = 0;
  int failures = 0;

  imem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES(DB), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .boot_done_i(boot_done_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
    .ld_wdata_i(ld_wdata_i), .ld_be_i(ld_be_i), .ld_gnt_o(ld_gnt_o),
    .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wen_o(mem_wen_o),
    .mem_rdata_i(mem_rdata_i), .run_o(run_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: synchronous, byte-writable, one-cycle read latency.
  logic [DW-1:0] memArr [DEPTH];
  logic [DW-1:0] refMem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      memArr[i] = 32'(i) * 32'h9E37_79B9;
      refMem[i] = 32'(i) * 32'h9E37_79B9;
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < DB; b++) begin
      if (mem_wen_o[b]) memArr[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
    end
    mem_rdata_i <= memArr[mem_addr_o];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, advanced once per cycle from the input rules.
  bit            mRun      = 1'b0;
  int            mDenied   = 0;
  int            mLastWord = 0;
  logic [DW-1:0] ifQ [$];
  logic [DW-1:0] ldQ [$];

  always @(negedge clk) begin
    bit expLd;
    bit expIf;
    int word;
    int ldWord;
    int ifWord;
    if (rst) begin
      mRun      = 1'b0;
      mDenied   = 0;
      mLastWord = 0;
    end else begin
      ldWord = int'(ld_addr_i / 4) % DEPTH;
      ifWord = int'(if_addr_i / 4) % DEPTH;
      if (!mRun) begin
        expLd = ld_req_i;
        expIf = 1'b0;
      end else begin
        expLd = ld_req_i && (!if_req_i || mDenied == LIMIT);
        expIf = if_req_i && !expLd;
      end
      word = expLd ? ldWord : (expIf ? ifWord : mLastWord);
      checkOutput("run_o", 32'(run_o), 32'(mRun));
      checkOutput("if_gnt", 32'(if_gnt_o), 32'(expIf));
      checkOutput("ld_gnt", 32'(ld_gnt_o), 32'(expLd));
      checkOutput("mem_addr", 32'(mem_addr_o), 32'(word));
      checkOutput("mem_wen", 32'(mem_wen_o), (expLd && ld_we_i) ? 32'(ld_be_i) : 32'd0);
      checkOutput("mem_wdata", mem_wdata_o, ld_wdata_i);
      if (expIf) ifQ.push_back(refMem[ifWord]);
      if (expLd && !ld_we_i) ldQ.push_back(refMem[ldWord]);
      if (expLd && ld_we_i) begin
        for (int b = 0; b < DB; b++) begin
          if (ld_be_i[b]) refMem[ldWord][b*8 +: 8] = ld_wdata_i[b*8 +: 8];
        end
      end
      mLastWord = word;
      if (mRun && ld_req_i && !expLd) mDenied = (mDenied < LIMIT) ? mDenied + 1 : LIMIT;
      else mDenied = 0;
      if (!mRun && boot_done_i) mRun = 1'b1;
    end
  end

  // Monitor: every queued read must come back exactly one cycle later, and nothing else.
  always @(posedge clk) begin
    logic [DW-1:0] expData;
    #2;
    if (ifQ.size() > 0) begin
      expData = ifQ.pop_front();
      checkOutput("if_rvalid", 32'(if_rvalid_o), 32'd1);
      if (if_rvalid_o) checkOutput("if_rdata", if_rdata_o, expData);
    end else begin
      checkOutput("if_rvalid_idle", 32'(if_rvalid_o), 32'd0);
    end
    if (ldQ.size() > 0) begin
      expData = ldQ.pop_front();
      checkOutput("ld_rvalid", 32'(ld_rvalid_o), 32'd1);
      if (ld_rvalid_o) checkOutput("ld_rdata", ld_rdata_o, expData);
    end else begin
      checkOutput("ld_rvalid_idle", 32'(ld_rvalid_o), 32'd0);
    end
  end

  task automatic applyStimulus(input bit r, input bit bd, input bit ifr, input logic [31:0] ifa,
                               input bit ldr, input bit we, input logic [31:0] lda,
                               input logic [DW-1:0] wd, input logic [DB-1:0] be);
    @(posedge clk);
    #1;
    rst         = r;
    boot_done_i = bd;
    if_req_i    = ifr;
    if_addr_i   = ifa;
    ld_req_i    = ldr;
    ld_we_i     = we;
    ld_addr_i   = lda;
    ld_wdata_i  = wd;
    ld_be_i     = be;
  endtask

  function automatic logic [31:0] randAddr();
    return (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int n;
    bit ldG;
    bit ifG;
    rst = 1'b1; boot_done_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
    ld_req_i = 1'b0; ld_we_i = 1'b0; ld_addr_i = '0; ld_wdata_i = '0; ld_be_i = '0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h0, 1, 1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(0, 0, 1, 32'h0, 1, 1, 32'h104, 32'h0000_0013, 4'hF);
    applyStimulus(0, 1, 1, 32'h0, 1, 0, 32'h104, 32'h0, 4'h0);
    applyStimulus(0, 0, 1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 1, 32'h104, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);

    n = 0;
    ldG = 1'b0;
    while (!ldG && n < 20) begin
      applyStimulus(0, 0, 1, 32'h8, 1, 0, 32'h104, 32'h0, 4'h0);
      @(negedge clk);
      #1;
      ldG = ld_gnt_o;
      n++;
    end
    if (!ldG) begin
      failures++;
      $display("[TB] FAIL starve_timeout actual=no_grant expected=grant after %0d cycles", n);
    end
    checkOutput("starve_cycles", 32'(n), 32'(LIMIT + 1));

    applyStimulus(0, 0, 0, 32'h0, 1, 1, 32'h100, 32'h0000_AAAA, 4'b0011);
    applyStimulus(0, 0, 1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 1, 32'h1100, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 0, 1, 32'h104, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 1, 32'h104, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 1, 32'h104, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    applyStimulus(0, 0, 1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0);

    for (int c = 0; c < 3000; c++) begin
      bit            r;
      bit            bd;
      bit            ifr;
      bit            ldr;
      bit            we;
      logic [31:0]   ifa;
      logic [31:0]   lda;
      logic [DW-1:0] wd;
      logic [DB-1:0] be;
      @(negedge clk);
      #1;
      ldG = ld_gnt_o;
      ifG = if_gnt_o;
      ifr = if_req_i; ifa = if_addr_i;
      ldr = ld_req_i; we = ld_we_i; lda = ld_addr_i; wd = ld_wdata_i; be = ld_be_i;
      if (!ifr || ifG) begin
        ifr = ($urandom_range(0, 3) != 0);
        ifa = randAddr();
      end
      if (!ldr || ldG || $urandom_range(0, 9) == 0) begin
        ldr = ($urandom_range(0, 2) == 0);
        we  = $urandom_range(0, 1) == 1;
        lda = randAddr();
        wd  = $urandom;
        be  = 4'($urandom_range(0, 15));
      end
      r  = ($urandom_range(0, 399) == 0);
      bd = ($urandom_range(0, 29) == 0);
      if (r) ldr = 1'b0;
      applyStimulus(r, bd, ifr, ifa, ldr, we, lda, wd, be);
    end

    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
